// File: rtl/hpi_responder_if.sv
// hpi_responder_if: HPI control strobes and interrupt between the host (master) and the chip-side responder (slave).
`timescale 1ns/1ps
interface hpi_responder_if;
  logic [1:0] OTG_ADDR;
  logic OTG_CS_N;
  logic OTG_RD_N;
  logic OTG_WR_N;
  logic OTG_RST_N;
  logic OTG_INT;
  modport master (output OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N, input OTG_INT);
  modport slave (input OTG_ADDR, OTG_CS_N, OTG_RD_N, OTG_WR_N, OTG_RST_N, output OTG_INT);
endinterface

// File: rtl/hpi_responder.sv
// hpi_responder: CY7C67200 HPI chip-side responder with word memory, bidirectional mailbox and STATUS.
// Define HPI_BOUNDS_CHECK_EN to flag out-of-range DATA accesses in sticky STATUS[15] (also raises OTG_INT).
`timescale 1ns/1ps
module hpi_responder #(
  parameter int DEPTH = 1024,
  parameter logic [15:0] RST_STATUS = 16'h0000
) (
  input  logic Clk,
  input  logic Reset_n,
  hpi_responder_if.slave otg,
  inout  wire [15:0] OTG_DATA,
  input  logic dev_mbx_wr,
  input  logic [15:0] dev_mbx_data,
  output logic host_mbx_valid,
  output logic [15:0] host_mbx_data,
  input  logic dev_mbx_ack
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [1:0] A_DATA = 2'd0, A_MBX = 2'd1, A_ADDR = 2'd2;
`ifdef HPI_BOUNDS_CHECK_EN
  localparam bit BOUNDS_EN = 1'b1;
`else
  localparam bit BOUNDS_EN = 1'b0;
`endif
  logic [1:0] s_addr, waddr;
  logic s_cs_n, s_rd_n, s_wr_n, p_rl, p_wl, stat0, stat15, drive, int_q;
  logic [15:0] s_data, wdata, rdata, addr_reg, out_mbx;
  logic [15:0] mem [DEPTH];
  logic srst, rl, wl, rd_start, commit, in_range, data_acc, mbx_commit, mem_we;
  logic stat0_n, stat15_n, hv_n;
  logic [15:0] rd_src, addr_n, out_mbx_n, hd_n;
  logic [AW-1:0] idx;
  always_comb begin
    srst = !otg.OTG_RST_N;
    rl = !s_cs_n && !s_rd_n;
    wl = !s_cs_n && !s_wr_n;
    rd_start = rl && !wl && !p_rl;
    commit = p_wl && !wl;
    in_range = {1'b0, addr_reg} < 17'(2 * DEPTH);
    idx = addr_reg[AW:1];
    data_acc = (rd_start && s_addr == A_DATA) || (commit && waddr == A_DATA);
    mbx_commit = commit && waddr == A_MBX;
    mem_we = commit && waddr == A_DATA && in_range && !srst;
    rd_src = s_addr == A_DATA ? (in_range ? mem[idx] : 16'h0000) :
             s_addr == A_MBX  ? out_mbx :
             s_addr == A_ADDR ? addr_reg :
             {stat15, RST_STATUS[14:2], host_mbx_valid, stat0};
    addr_n = srst ? '0 : data_acc ? addr_reg + 16'd2 : (commit && waddr == A_ADDR) ? wdata : addr_reg;
    // a device post in the same cycle as a host MAILBOX read keeps the pending flag set
    out_mbx_n = srst ? '0 : dev_mbx_wr ? dev_mbx_data : out_mbx;
    stat0_n = !srst && (dev_mbx_wr || (stat0 && !(rd_start && s_addr == A_MBX)));
    stat15_n = !srst && (stat15 || (BOUNDS_EN && data_acc && !in_range));
    hv_n = !srst && (mbx_commit || (host_mbx_valid && !dev_mbx_ack));
    hd_n = srst ? '0 : mbx_commit ? wdata : host_mbx_data;
  end
  always_ff @(posedge Clk or negedge Reset_n)
    if (!Reset_n) begin
      s_addr <= '0;
      waddr <= '0;
      {s_cs_n, s_rd_n, s_wr_n} <= '1;
      {p_rl, p_wl, stat0, stat15, drive, int_q, host_mbx_valid} <= '0;
      {s_data, wdata, rdata, addr_reg, out_mbx, host_mbx_data} <= '0;
    end else begin
      s_addr <= otg.OTG_ADDR;
      s_cs_n <= otg.OTG_CS_N || srst;
      s_rd_n <= otg.OTG_RD_N || srst;
      s_wr_n <= otg.OTG_WR_N || srst;
      s_data <= OTG_DATA;
      p_rl <= rl && !srst;
      p_wl <= wl && !srst;
      wdata <= (wl && !rl) ? s_data : wdata;
      waddr <= (wl && !rl) ? s_addr : waddr;
      rdata <= srst ? '0 : rd_start ? rd_src : rdata;
      drive <= rl && !wl && !srst;
      addr_reg <= addr_n;
      out_mbx <= out_mbx_n;
      stat0 <= stat0_n;
      stat15 <= stat15_n;
      host_mbx_valid <= hv_n;
      host_mbx_data <= hd_n;
      int_q <= stat0_n || stat15_n;
    end
  always_ff @(posedge Clk)
    if (mem_we) mem[idx] <= wdata;
  assign OTG_DATA = drive ? rdata : 16'hzzzz;
  assign otg.OTG_INT = int_q;
endmodule
